weight_pingpong_buffer: RTL and testbench

//  Double-buffered weight store that feeds the systolic array. Host (RPi) interface

---
 rtl/tpu_pkg.sv | 16 +
 rtl/weight_bank.sv | 69 ++++++
 rtl/weight_pingpong_buffer.sv | 134 +++++++++++++
 tb/tb_weight_pingpong_buffer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared types and helpers for the weight ping-pong buffer and its banks.
package tpu_pkg;

    localparam int WEIGHT_W = 8;

    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } buf_state_t;

    // Bit offset of lane 'lane' inside a packed vector of 'width'-bit lanes.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/weight_bank.sv
// One weight bank: DEPTH x DATA_W registers, a single write port, a per-bank
// fill count, and LANES combinational read ports with mod-DEPTH wrap. Entries
// at or beyond the fill count read as zero so short loads come out zero-padded.
module weight_bank
    import tpu_pkg::*;
#(
    parameter int DATA_W = WEIGHT_W,
    parameter int DEPTH  = 4,
    parameter int LANES  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    cnt_en,
    input  logic [ADDR_W:0]         cnt_in,
    input  logic [ADDR_W-1:0]       rd_base,
    output logic [LANES*DATA_W-1:0] rd_lanes
);

    // Wide enough to hold rd_base + (LANES-1) before the modulo reduction.
    localparam int SUM_W = ADDR_W + 2;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_d;
    logic [SUM_W-1:0]  rd_idx;

    // Next-state for storage: one word written per cycle, count latched at end of load.
    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
        if (cnt_en) begin
            count_d = cnt_in;
        end
    end

    // Storage registers; reset clears all data and the fill count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
        end
    end

    // Read window: lane k sees entry (rd_base + k) mod DEPTH, masked by the fill count.
    always_comb begin
        rd_lanes = '0;
        rd_idx   = '0;
        for (int k = 0; k < LANES; k++) begin
            rd_idx = (SUM_W'(rd_base) + SUM_W'(k)) % SUM_W'(DEPTH);
            if (rd_idx < SUM_W'(count_q)) begin
                rd_lanes[lane_lsb(k, DATA_W) +: DATA_W] = mem_q[rd_idx[ADDR_W-1:0]];
            end
        end
    end

endmodule

// File: rtl/weight_pingpong_buffer.sv
// Double-buffered weight store for the systolic array. The host fills the
// shadow bank while the array reads LANES-wide windows from the active bank;
// a level swap request exchanges the banks once the shadow bank is full.
module weight_pingpong_buffer
    import tpu_pkg::*;
#(
    parameter int DATA_W = WEIGHT_W,
    parameter int DEPTH  = 4,
    parameter int LANES  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [DATA_W-1:0]       load_data,
    input  logic                    load_last,
    output logic                    shadow_full,
    input  logic                    swap_req,
    output logic                    swap_ack,
    output logic                    active_bank,
    input  logic                    rd_en,
    input  logic [ADDR_W-1:0]       rd_base,
    output logic [LANES*DATA_W-1:0] weights_out,
    output logic                    weights_valid
);

    localparam int PTR_W = ADDR_W + 1;

    buf_state_t              state_q, state_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic                    active_bank_q, active_bank_d;
    logic                    swap_ack_q, swap_ack_d;
    logic [LANES*DATA_W-1:0] weights_q, weights_d;
    logic                    weights_valid_q, weights_valid_d;

    logic                    accept;
    logic                    last_word;
    logic [PTR_W-1:0]        count_in;
    logic [LANES*DATA_W-1:0] lanes0, lanes1, active_lanes;

    assign accept    = load_valid && (state_q == LOAD);
    assign last_word = accept && (load_last || (wr_ptr_q == PTR_W'(DEPTH - 1)));
    assign count_in  = wr_ptr_q + PTR_W'(1);

    weight_bank #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .LANES(LANES), .ADDR_W(ADDR_W)
    ) u_bank0 (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (accept && active_bank_q),
        .wr_addr  (wr_ptr_q[ADDR_W-1:0]),
        .wr_data  (load_data),
        .cnt_en   (last_word && active_bank_q),
        .cnt_in   (count_in),
        .rd_base  (rd_base),
        .rd_lanes (lanes0)
    );

    weight_bank #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .LANES(LANES), .ADDR_W(ADDR_W)
    ) u_bank1 (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (accept && !active_bank_q),
        .wr_addr  (wr_ptr_q[ADDR_W-1:0]),
        .wr_data  (load_data),
        .cnt_en   (last_word && !active_bank_q),
        .cnt_in   (count_in),
        .rd_base  (rd_base),
        .rd_lanes (lanes1)
    );

    assign active_lanes = active_bank_q ? lanes1 : lanes0;

    // Shadow-side FSM and read capture; reads always see the pre-swap active bank.
    always_comb begin
        state_d         = state_q;
        wr_ptr_d        = wr_ptr_q;
        active_bank_d   = active_bank_q;
        swap_ack_d      = 1'b0;
        weights_d       = weights_q;
        weights_valid_d = rd_en;
        if (rd_en) begin
            weights_d = active_lanes;
        end
        case (state_q)
            LOAD: begin
                if (accept) begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    if (last_word) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (swap_req) begin
                    active_bank_d = !active_bank_q;
                    swap_ack_d    = 1'b1;
                    wr_ptr_d      = '0;
                    state_d       = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Control and output registers; reset discards any partial load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= LOAD;
            wr_ptr_q        <= '0;
            active_bank_q   <= 1'b0;
            swap_ack_q      <= 1'b0;
            weights_q       <= '0;
            weights_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            active_bank_q   <= active_bank_d;
            swap_ack_q      <= swap_ack_d;
            weights_q       <= weights_d;
            weights_valid_q <= weights_valid_d;
        end
    end

    assign load_ready    = (state_q == LOAD);
    assign shadow_full   = (state_q == FULL);
    assign swap_ack      = swap_ack_q;
    assign active_bank   = active_bank_q;
    assign weights_out   = weights_q;
    assign weights_valid = weights_valid_q;

endmodule

// File: tb/tb_weight_pingpong_buffer.sv
// Bench for weight_pingpong_buffer: two instances (DEPTH=4/LANES=4 and
// DEPTH=6/LANES=3) share one stimulus stream selected by 'sel'. A bank-level
// model tracks both instances and is compared every cycle; directed steps add
// hand-computed expectations.
module tb_weight_pingpong_buffer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sel = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = '0;
    logic       load_last = 1'b0;
    logic       swap_req = 1'b0;
    logic       rd_en = 1'b0;
    logic [2:0] rd_base = '0;

    int vectors = 0;
    int miscompares = 0;

    logic a_lv, a_ll, a_sr, a_re;
    logic b_lv, b_ll, b_sr, b_re;
    assign a_lv = load_valid & ~sel;
    assign a_ll = load_last  & ~sel;
    assign a_sr = swap_req   & ~sel;
    assign a_re = rd_en      & ~sel;
    assign b_lv = load_valid & sel;
    assign b_ll = load_last  & sel;
    assign b_sr = swap_req   & sel;
    assign b_re = rd_en      & sel;

    logic        a_ready, a_full, a_ack, a_active, a_wval;
    logic [31:0] a_wout;
    logic        b_ready, b_full, b_ack, b_active, b_wval;
    logic [23:0] b_wout;

    weight_pingpong_buffer #(.DATA_W(8), .DEPTH(4), .LANES(4)) dut_a (
        .clk(clk), .rst(rst),
        .load_valid(a_lv), .load_ready(a_ready), .load_data(load_data), .load_last(a_ll),
        .shadow_full(a_full), .swap_req(a_sr), .swap_ack(a_ack), .active_bank(a_active),
        .rd_en(a_re), .rd_base(rd_base[1:0]), .weights_out(a_wout), .weights_valid(a_wval)
    );

    weight_pingpong_buffer #(.DATA_W(8), .DEPTH(6), .LANES(3)) dut_b (
        .clk(clk), .rst(rst),
        .load_valid(b_lv), .load_ready(b_ready), .load_data(load_data), .load_last(b_ll),
        .shadow_full(b_full), .swap_req(b_sr), .swap_ack(b_ack), .active_bank(b_active),
        .rd_en(b_re), .rd_base(rd_base), .weights_out(b_wout), .weights_valid(b_wval)
    );

    // Selected-instance views for the directed checks.
    logic        cur_ready, cur_full, cur_ack, cur_active, cur_wval;
    logic [31:0] cur_wout;
    assign cur_ready  = sel ? b_ready  : a_ready;
    assign cur_full   = sel ? b_full   : a_full;
    assign cur_ack    = sel ? b_ack    : a_ack;
    assign cur_active = sel ? b_active : a_active;
    assign cur_wval   = sel ? b_wval   : a_wval;
    assign cur_wout   = sel ? {8'h00, b_wout} : a_wout;

    always #5 clk = ~clk;

    // Model state per instance: two banks of words, fill counts, which bank is read.
    int          mbank [2][2][8];
    int          mcnt  [2][2];
    int          mact  [2];
    bit          mfull [2];
    int          mwp   [2];
    bit          mack  [2];
    logic [31:0] mwout [2];
    bit          mval  [2];

    function automatic int depthOf(input int i);
        return (i == 0) ? 4 : 6;
    endfunction

    function automatic int lanesOf(input int i);
        return (i == 0) ? 4 : 3;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            for (int b = 0; b < 2; b++) begin
                mcnt[i][b] = 0;
                for (int j = 0; j < 8; j++) mbank[i][b][j] = 0;
            end
            mact[i] = 0; mfull[i] = 1'b0; mwp[i] = 0;
            mack[i] = 1'b0; mwout[i] = '0; mval[i] = 1'b0;
        end
    endtask

    task automatic modelStep(input int i, input bit lv, input int ld, input bit ll,
                             input bit sr, input bit re, input int rb);
        int d, sh, idx, v;
        d  = depthOf(i);
        sh = 1 - mact[i];
        if (re) begin
            mwout[i] = '0;
            for (int k = 0; k < lanesOf(i); k++) begin
                idx = (rb + k) % d;
                v = (idx < mcnt[i][mact[i]]) ? mbank[i][mact[i]][idx] : 0;
                mwout[i] = mwout[i] | (32'(v) << (8 * k));
            end
        end
        mval[i] = re;
        mack[i] = 1'b0;
        if (!mfull[i]) begin
            if (lv) begin
                mbank[i][sh][mwp[i]] = ld;
                mwp[i]++;
                if (ll || mwp[i] == d) begin
                    mcnt[i][sh] = mwp[i];
                    mfull[i] = 1'b1;
                end
            end
        end else if (sr) begin
            mact[i] = sh;
            mack[i] = 1'b1;
            mwp[i]  = 0;
            mfull[i] = 1'b0;
        end
    endtask

    task automatic compareAll();
        checkOutput("a.load_ready",    32'(a_ready),  32'(!mfull[0]));
        checkOutput("a.shadow_full",   32'(a_full),   32'(mfull[0]));
        checkOutput("a.swap_ack",      32'(a_ack),    32'(mack[0]));
        checkOutput("a.active_bank",   32'(a_active), 32'(mact[0]));
        checkOutput("a.weights_valid", 32'(a_wval),   32'(mval[0]));
        checkOutput("a.weights_out",   a_wout,        mwout[0]);
        checkOutput("b.load_ready",    32'(b_ready),  32'(!mfull[1]));
        checkOutput("b.shadow_full",   32'(b_full),   32'(mfull[1]));
        checkOutput("b.swap_ack",      32'(b_ack),    32'(mack[1]));
        checkOutput("b.active_bank",   32'(b_active), 32'(mact[1]));
        checkOutput("b.weights_valid", 32'(b_wval),   32'(mval[1]));
        checkOutput("b.weights_out",   {8'h00, b_wout}, mwout[1]);
    endtask

    // Advance the model on every clock edge (or reset), then compare after outputs settle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            modelReset();
        end else begin
            modelStep(0, a_lv, int'(load_data), a_ll, a_sr, a_re, int'(rd_base[1:0]));
            modelStep(1, b_lv, int'(load_data), b_ll, b_sr, b_re, int'(rd_base));
        end
        #2;
        compareAll();
    end

    task automatic applyStimulus(input logic [7:0] d, input logic last);
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
    endtask

    task automatic endLoad();
        @(negedge clk);
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_data  = '0;
    endtask

    task automatic doSwap(input string name);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        swap_req = 1'b1;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (cur_ack) seen = 1'b1;
        end
        checkOutput(name, 32'(seen), 32'd1);
        @(negedge clk);
        swap_req = 1'b0;
    endtask

    task automatic readCheck(input logic [2:0] base, input logic [31:0] exp, input string name);
        @(negedge clk);
        rd_en   = 1'b1;
        rd_base = base;
        @(posedge clk);
        #1;
        checkOutput(name, cur_wout, exp);
        checkOutput({name, "_valid"}, 32'(cur_wval), 32'd1);
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_ready", 32'(cur_ready), 32'd1);
        checkOutput("reset_wout", cur_wout, 32'd0);

        // Basic load, swap, read on the 4x4 instance.
        applyStimulus(8'd1, 1'b0); applyStimulus(8'd2, 1'b0);
        applyStimulus(8'd3, 1'b0); applyStimulus(8'd4, 1'b0);
        endLoad();
        checkOutput("t1_full", 32'(cur_full), 32'd1);
        doSwap("t1_swap_ack");
        readCheck(3'd0, 32'h04030201, "t1_read");

        // Wrap-around window.
        applyStimulus(8'd10, 1'b0); applyStimulus(8'd20, 1'b0);
        applyStimulus(8'd30, 1'b0); applyStimulus(8'd40, 1'b0);
        endLoad();
        doSwap("t2_swap_ack");
        readCheck(3'd2, 32'h140A281E, "t2_wrap");

        // Short load is zero-padded over stale shadow data.
        applyStimulus(8'd7, 1'b0); applyStimulus(8'd8, 1'b1);
        endLoad();
        checkOutput("t3_full", 32'(cur_full), 32'd1);
        doSwap("t3_swap_ack");
        readCheck(3'd0, 32'h00000807, "t3_short");

        // Swap request held through the whole load.
        @(negedge clk);
        swap_req = 1'b1;
        applyStimulus(8'd5, 1'b0); applyStimulus(8'd6, 1'b0);
        applyStimulus(8'd7, 1'b0); applyStimulus(8'd8, 1'b0);
        endLoad();
        checkOutput("t4_full", 32'(cur_full), 32'd1);
        checkOutput("t4_no_early_ack", 32'(cur_ack), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("t4_ack", 32'(cur_ack), 32'd1);
        checkOutput("t4_ready", 32'(cur_ready), 32'd1);
        checkOutput("t4_active", 32'(cur_active), 32'd0);
        @(negedge clk);
        swap_req = 1'b0;

        // Back-to-back reads across the swap edge.
        applyStimulus(8'd11, 1'b0); applyStimulus(8'd12, 1'b0);
        applyStimulus(8'd13, 1'b0); applyStimulus(8'd14, 1'b0);
        endLoad();
        @(negedge clk);
        rd_en = 1'b1; rd_base = 3'd0; swap_req = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t5_pre_swap", cur_wout, 32'h08070605);
        checkOutput("t5_ack", 32'(cur_ack), 32'd1);
        @(negedge clk);
        swap_req = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("t5_post_swap", cur_wout, 32'h0E0D0C0B);
        checkOutput("t5_valid", 32'(cur_wval), 32'd1);
        @(negedge clk);
        rd_en = 1'b0;

        // Asynchronous reset in the middle of a load.
        applyStimulus(8'd21, 1'b0); applyStimulus(8'd22, 1'b0);
        endLoad();
        #1 rst = 1'b1;
        #1;
        checkOutput("t6_async_wout", cur_wout, 32'd0);
        checkOutput("t6_async_active", 32'(cur_active), 32'd0);
        checkOutput("t6_async_ready", 32'(cur_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        readCheck(3'd0, 32'd0, "t6_read_zero");

        // Rerun on the DEPTH=6, LANES=3 instance.
        @(negedge clk);
        sel = 1'b1;
        for (int w = 1; w <= 6; w++) applyStimulus(8'(w), 1'b0);
        endLoad();
        doSwap("b1_swap_ack");
        readCheck(3'd0, 32'h00030201, "b1_read");
        readCheck(3'd4, 32'h00010605, "b1_wrap");

        for (int w = 1; w <= 6; w++) applyStimulus(8'(w * 10), 1'b0);
        endLoad();
        doSwap("b2_swap_ack");
        readCheck(3'd7, 32'h00281E14, "b2_base_mod");
        readCheck(3'd5, 32'h00140A3C, "b2_wrap");

        applyStimulus(8'd7, 1'b0); applyStimulus(8'd8, 1'b1);
        endLoad();
        doSwap("b3_swap_ack");
        readCheck(3'd0, 32'h00000807, "b3_short");

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
